// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and default word width.
package uart_pkg;

  localparam int unsigned UART_DBIT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } tx_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Dual-pointer register array: synchronous write port, combinational read at rd_ptr.
module uart_fifo_mem #(
  parameter int unsigned DBIT   = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [DBIT-1:0] wr_data,
  input  logic            rd_en,
  output logic [DBIT-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [DBIT-1:0]   mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a UART transmitter with registered one-cycle launch pulses.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DBIT   = UART_DBIT,
  parameter int unsigned ADDR_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [DBIT-1:0] wr_data,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_din,
  input  logic            tx_done_tick
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic            overflow
`endif
);

  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  tx_state_t       state;
  tx_state_t       state_next;
  logic            accept;
  logic            launch;
  logic [DBIT-1:0] rd_data;

  assign full   = (count == DEPTH);
  assign empty  = (count == '0);
  assign accept = wr_en & ~full;

  uart_fifo_mem #(
    .DBIT   (DBIT),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_data (wr_data),
    .rd_en   (launch),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (!empty)      state_next = BUSY;
      BUSY: if (tx_done_tick) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Launch is only ever taken from IDLE, so a done tick can never coincide with one.
  always_comb begin
    launch = (state == IDLE) && !empty;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_start <= 1'b0;
      tx_din   <= '0;
    end else begin
      tx_start <= launch;
      if (launch) tx_din <= rd_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      unique case ({accept, launch})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             overflow <= 1'b0;
    else if (wr_en & full) overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized and directed bench for uart_tx_fifo against a queue-based reference model.
// Define UART_TX_FIFO_OVF_EN to also check the overflow flag.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       tx_start;
  logic [7:0] tx_din;
  logic       tx_done_tick;
`ifdef UART_TX_FIFO_OVF_EN
  logic       overflow;
`endif

  uart_tx_fifo #(
    .DBIT   (8),
    .ADDR_W (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .overflow     (overflow)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: words waiting in the FIFO, and whether the transmitter owns a word.
  logic [7:0] m_q[$];
  bit         m_busy;
  bit         m_start;
  logic [7:0] m_din;
  bit         m_ovf;
  int         age;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_busy  = 0;
    m_start = 0;
    m_din   = 8'h00;
    m_ovf   = 0;
    age     = -1;
  endtask

  task automatic compare_all();
    check("tx_start", 32'(tx_start), 32'(m_start));
    check("tx_din",   32'(tx_din),   32'(m_din));
    check("count",    32'(count),    32'(m_q.size()));
    check("full",     32'(full),     32'(m_q.size() == DEPTH));
    check("empty",    32'(empty),    32'(m_q.size() == 0));
`ifdef UART_TX_FIFO_OVF_EN
    check("overflow", 32'(overflow), 32'(m_ovf));
`endif
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic step(input bit wr, input logic [7:0] data, input bit done);
    bit launch_now;
    bit accept_now;
    wr_en        = wr;
    wr_data      = data;
    tx_done_tick = done;
    @(posedge clk);
    launch_now = !m_busy && (m_q.size() != 0);
    accept_now = wr && (m_q.size() < DEPTH);
    if (wr && m_q.size() == DEPTH) m_ovf = 1;
    if (launch_now) begin
      m_din   = m_q.pop_front();
      m_start = 1;
      m_busy  = 1;
    end else begin
      m_start = 0;
      if (m_busy && done) m_busy = 0;
    end
    if (accept_now) m_q.push_back(data);
    #1;
    compare_all();
    if (tx_start) age = 0;
    else if (age >= 0) age++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_din",   32'(tx_din),   32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [7:0] seen[$];

  initial begin
    wr_en = 1'b0; wr_data = 8'h00; tx_done_tick = 1'b0; reset = 1'b0;
    model_clear();
    #3;
    do_reset();

    // Single word: visible one edge after the write, launched at the next.
    step(1, 8'hA5, 0);
    check("a5_count1", 32'(count), 32'd1);
    step(0, 8'h00, 0);
    check("a5_start", 32'(tx_start), 32'd1);
    check("a5_din",   32'(tx_din),   32'hA5);
    check("a5_count0", 32'(count), 32'd0);
    check("a5_empty", 32'(empty), 32'd1);
    step(0, 8'h00, 0);
    check("a5_pulse1", 32'(tx_start), 32'd0);
    step(0, 8'h00, 1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0);

    // Three words, each done 20 cycles after its launch.
    do_reset();
    seen.delete();
    for (int i = 1; i <= 3; i++) begin
      step(1, 8'(i), 0);
      if (tx_start) seen.push_back(tx_din);
    end
    for (int c = 0; c < 90; c++) begin
      step(0, 8'h00, age == 19);
      if (tx_start) seen.push_back(tx_din);
    end
    check("seq_n", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      check("seq_0", 32'(seen[0]), 32'h01);
      check("seq_1", 32'(seen[1]), 32'h02);
      check("seq_2", 32'(seen[2]), 32'h03);
    end

    // Transmitter held busy, 17 writes into a 16-deep FIFO.
    do_reset();
    step(1, 8'h10, 0);
    step(0, 8'h00, 0);
    for (int i = 0; i < 17; i++) begin
      step(1, 8'(8'h20 + i), 0);
      if (i == 15) begin
        check("fill_full16", 32'(full), 32'd1);
        check("fill_cnt16", 32'(count), 32'd16);
      end
    end
    check("fill_cnt17", 32'(count), 32'd16);
`ifdef UART_TX_FIFO_OVF_EN
    check("fill_ovf", 32'(overflow), 32'd1);
`endif
    // Done, then a write on the launch edge: still full at that edge, so dropped.
    step(0, 8'h00, 1);
    step(1, 8'hEE, 0);
    check("full_launch_cnt", 32'(count), 32'd15);
    check("full_launch_din", 32'(tx_din), 32'h20);
    for (int c = 0; c < 70; c++) step(0, 8'h00, (c % 4) == 3);
    check("drain_empty", 32'(empty), 32'd1);

    // Count 5 while busy, then write coinciding with a dequeue; then wrap pointers.
    do_reset();
    step(1, 8'h40, 0);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h41 + i), 0);
    check("c5_pre", 32'(count), 32'd5);
    step(0, 8'h00, 1);
    step(1, 8'h50, 0);
    check("c5_post", 32'(count), 32'd5);
    for (int c = 0; c < 60; c++) step((c % 2) == 0 && c < 28, 8'(8'h60 + c), (c % 3) == 2);

    // Reset mid-transmission with words queued; a late done must not launch.
    do_reset();
    step(1, 8'h70, 0);
    for (int i = 0; i < 4; i++) step(1, 8'(8'h71 + i), 0);
    check("mid_cnt4", 32'(count), 32'd4);
    #2;
    do_reset();
    step(0, 8'h00, 1);
    check("post_rst_nolaunch", 32'(tx_start), 32'd0);
    step(0, 8'h00, 0);
    check("post_rst_nolaunch2", 32'(tx_start), 32'd0);
    check("post_rst_empty", 32'(empty), 32'd1);

    // Randomized traffic with phases of heavy and light writing.
    for (int c = 0; c < 1500; c++) begin
      int unsigned wr_pct;
      wr_pct = ((c / 150) % 2 == 0) ? 80 : 15;
      step($urandom_range(99) < wr_pct, 8'($urandom), $urandom_range(7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
